// File: rtl/input_shifter.sv
// -----------------------------------------------------------------------------
// input_shifter
//
// Write-data conditioning stage for the configurable-width SRAM macro.
// The low 2^conf bits of the incoming word are tiled LSB-aligned across the
// full 32-bit array write bus, so every column group sees the same narrow
// word and the column mux alone decides which group is written. One
// registered pipeline stage sits between the replication logic and the
// bitline write drivers.
//
// Ports
//   clk        in   1   system clock, rising edge only
//   rst_n      in   1   asynchronous active-low reset
//   D          in  32   raw write data; only the low 2^conf bits matter
//   conf       in   3   word width select: W = 2^conf for 0..5;
//                       6 and 7 behave as 5 (full-width pass-through)
//   in_valid   in   1   capture D/conf on this rising edge
//   din        out 32   replicated write data, registered
//   out_valid  out  1   din holds a word captured on the last edge
// -----------------------------------------------------------------------------
module input_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] D,
    input  logic [2:0]  conf,
    input  logic        in_valid,
    output logic [31:0] din,
    output logic        out_valid
);

    logic [31:0] w_rep;
    logic [31:0] r_din;
    logic        r_valid;

    // Replication network. Each case picks only the low W bits of D, so the
    // bits above W-1 never reach the register.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_rep unassigned,
        // which would otherwise infer a latch.
        w_rep = D;
        unique case (conf)
            3'd0:    w_rep = {32{D[0]}};
            3'd1:    w_rep = {16{D[1:0]}};
            3'd2:    w_rep = {8{D[3:0]}};
            3'd3:    w_rep = {4{D[7:0]}};
            3'd4:    w_rep = {2{D[15:0]}};
            default: w_rep = D;          // 5, and reserved codes 6/7
        endcase
    end

    // Pipeline register. Data loads only on a valid input and otherwise holds;
    // the valid flag is a plain registered copy of in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset too, because the bus must read
            // zero immediately on reset and until the first new capture.
            r_din   <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all sequential state.
            r_valid <= in_valid;
            if (in_valid) begin
                r_din <= w_rep;
            end
        end
    end

    assign din       = r_din;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_input_shifter.sv
// -----------------------------------------------------------------------------
// tb_input_shifter
//
// Self-checking bench for input_shifter. Expected outputs come from a
// reference model computed directly from the rule din[i] = D[i mod W],
// W = 2^conf (W = 32 for conf >= 5), plus a 1-cycle registered pipeline with
// hold-on-idle and asynchronous clear.
// -----------------------------------------------------------------------------
module tb_input_shifter;

    logic        clk;
    logic        rst_n;
    logic [31:0] D;
    logic [2:0]  conf;
    logic        in_valid;
    logic [31:0] din;
    logic        out_valid;

    int n_vec;
    int n_err;

    // Model state: what the outputs must show after the most recent edge.
    logic [31:0] exp_din;
    logic        exp_valid;

    input_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D         (D),
        .conf      (conf),
        .in_valid  (in_valid),
        .din       (din),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, want);
        end
    endtask

    // Reference model: tile the low W bits of d across 32 bits.
    function automatic logic [31:0] ref_rep(input logic [31:0] d, input logic [2:0] c);
        int w;
        logic [31:0] r;
        w = (c >= 3'd5) ? 32 : (1 << c);
        for (int i = 0; i < 32; i++) r[i] = d[i % w];
        return r;
    endfunction

    // Drive inputs (called away from the edge), take one rising edge,
    // advance the model, then sample #1 after the edge.
    task automatic step(input string tag, input logic [31:0] d, input logic [2:0] c,
                        input logic v);
        D        = d;
        conf     = c;
        in_valid = v;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_din   = 32'h0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) exp_din = ref_rep(d, c);
        end
        check({tag, ".din"}, din, exp_din);
        check({tag, ".vld"}, {31'b0, out_valid}, {31'b0, exp_valid});
    endtask

    // Assert reset asynchronously and confirm outputs clear without an edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        exp_din   = 32'h0;
        exp_valid = 1'b0;
        check({tag, ".din"}, din, 32'h0);
        check({tag, ".vld"}, {31'b0, out_valid}, 32'h0);
    endtask

    logic [31:0] sweep [6];
    int          n_valid;
    logic [31:0] rd;
    logic [2:0]  rc;
    logic        rv;

    initial begin
        n_vec = 0;
        n_err = 0;
        sweep[0] = 32'h0000_0000; sweep[1] = 32'hAAAA_AAAA; sweep[2] = 32'hEEEE_EEEE;
        sweep[3] = 32'h0E0E_0E0E; sweep[4] = 32'h000E_000E; sweep[5] = 32'h0000_000E;

        // Reset with all-ones data and valid high, no clock edge yet.
        D        = 32'hFFFF_FFFF;
        conf     = 3'd5;
        in_valid = 1'b1;
        rst_n    = 1'b1;
        #1;
        async_reset("rst_init");
        #1;
        rst_n = 1'b1;               // released well before the first edge
        step("rst_first", 32'hFFFF_FFFF, 3'd5, 1'b1);

        // Width sweep, back-to-back, D = 14.
        for (int c = 0; c < 6; c++) begin
            D = 32'd14; conf = 3'(c); in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d.din", c), din, sweep[c]);
            check($sformatf("sweep%0d.vld", c), {31'b0, out_valid}, 32'h1);
        end
        exp_din = sweep[5]; exp_valid = 1'b1;

        // Upper-bit masking.
        step("mask_c0", 32'hDEAD_BE01, 3'd0, 1'b1);
        check("mask_c0.lit", din, 32'hFFFF_FFFF);
        step("mask_c3", 32'hDEAD_BE01, 3'd3, 1'b1);
        check("mask_c3.lit", din, 32'h0101_0101);

        // Reserved codes behave as pass-through.
        step("resv6", 32'h1234_5678, 3'd6, 1'b1);
        check("resv6.lit", din, 32'h1234_5678);
        step("resv7", 32'h1234_5678, 3'd7, 1'b1);
        check("resv7.lit", din, 32'h1234_5678);

        // Hold behaviour while idle.
        step("hold_cap", 32'd14, 3'd2, 1'b1);
        step("hold_i0", 32'hCAFE_F00D, 3'd0, 1'b0);
        check("hold_i0.lit", din, 32'hEEEE_EEEE);
        step("hold_i1", 32'h5555_1234, 3'd4, 1'b0);
        check("hold_i1.lit", din, 32'hEEEE_EEEE);

        // Mid-stream reset discards the held word; outputs stay 0 until new valid.
        async_reset("rst_mid");
        #1;
        rst_n = 1'b1;
        step("post_rst_idle", 32'hFFFF_FFFF, 3'd5, 1'b0);
        check("post_rst_idle.lit", din, 32'h0);

        // Randomized run: 1000 valid cycles with idle gaps and reset pulses.
        n_valid = 0;
        while (n_valid < 1000) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rnd_rst");
                if ($urandom_range(0, 1) == 1) begin
                    // Hold reset across an edge with valid data applied.
                    step("rnd_rst_held", $urandom, 3'($urandom_range(0, 7)), 1'b1);
                end
                #1;
                rst_n = 1'b1;
            end
            rd = $urandom;
            rc = 3'($urandom_range(0, 7));
            rv = ($urandom_range(0, 4) != 0);
            step("rnd", rd, rc, rv);
            if (rv) n_valid++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_shifter.md
# input_shifter

Write-data conditioning stage for the configurable-width SRAM macro. It takes a 32-bit data word and a width configuration, and replicates the low 2^conf bits of the word across all 32 bits of the array write bus. Every column group therefore sees the same narrow word, and column muxing selects which group is written. It sits between the SRAM wrapper's write-data input and the bitline write drivers, with one registered pipeline stage.

## Interface
Parameters:
- none; the data width is fixed at 32 bits and `conf` is fixed at 3 bits.

Ports:
- `clk`  input  1  system clock. Single clock domain; the block uses only its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `D`  input  32  raw write data. Only the low 2^conf bits are significant.
- `conf`  input  3  word-width select. Word width = 2^conf bits for `conf` 0..5 (1, 2, 4, 8, 16, 32).
- `in_valid`  input  1  `D` and `conf` are valid this cycle; capture them.
- `din`  output  32  replicated write data, registered.
- `out_valid`  output  1  `din` holds a newly captured result.

## Operation
- Define W = 2^conf.
- Required result: `din[i] = D[i mod W]` for i = 0..31. The low W bits of `D` are tiled 32/W times, LSB-aligned.
- `conf`=0 (W=1): all 32 bits equal `D[0]`.
- `conf`=1 (W=2): the pattern `D[1:0]` repeats 16 times.
- `conf`=2 (W=4): `D[3:0]` repeats 8 times.
- `conf`=3 (W=8): `D[7:0]` repeats 4 times.
- `conf`=4 (W=16): `D[15:0]` repeats 2 times.
- `conf`=5 (W=32): `din` = `D` (pass-through).
- `conf`=6 or 7 (reserved): treated exactly as `conf`=5, i.e. pass-through. No error flag is raised.
- For W < 32, bits of `D` above bit W-1 are ignored completely and must not influence `din`.
- The replication logic is purely combinational from (`D`, `conf`) to the pipeline register. It contains no other state.

## Timing
- Latency is 1 cycle. On a rising edge of `clk` with `in_valid`=1, the register loads the replicated value of the current `D`/`conf`; `din` shows it after that edge.
- `out_valid` is a registered copy of `in_valid` and is aligned with `din`.
- On an edge with `in_valid`=0, `din` holds its previous value and `out_valid` goes to 0.
- Back-to-back `in_valid` is accepted every cycle (full throughput). There is no backpressure input.
- A change of `conf` between consecutive valid inputs takes effect on the very next captured word. There is no settling cycle.
- Reset: `rst_n`=0 forces `din`=32'h0000_0000 and `out_valid`=0 immediately, without waiting for `clk`. Reset held low keeps both outputs at 0.
- Reset release: removal should be synchronous to `clk`. The first capture occurs on the first rising edge with `rst_n`=1 and `in_valid`=1.
- Reset asserted mid-stream discards any in-flight word. After release, outputs stay 0 until a new valid input arrives.

## Test plan
- Reset: assert `rst_n`=0 with `D`=32'hFFFF_FFFF and `in_valid`=1, with no clock edge -> `din`=0 and `out_valid`=0 immediately. Release reset, clock once -> `din`=32'hFFFF_FFFF and `out_valid`=1.
- Width sweep with `D`=32'd14 and `in_valid`=1, stepping `conf` 0..5 on consecutive cycles -> `din` must be, in order, 32'h0000_0000, 32'hAAAA_AAAA, 32'hEEEE_EEEE, 32'h0E0E_0E0E, 32'h000E_000E, 32'h0000_000E, each one cycle after its input.
- Upper-bit masking: `D`=32'hDEAD_BE01 with `conf`=0 -> `din`=32'hFFFF_FFFF. Same `D` with `conf`=3 -> `din`=32'h0101_0101.
- Reserved codes: `D`=32'h1234_5678 with `conf`=6 and with `conf`=7 -> `din`=32'h1234_5678 for both.
- Hold behaviour: capture `D`=32'd14 with `conf`=2, then drive `in_valid`=0 while changing `D` and `conf` -> `din` stays 32'hEEEE_EEEE and `out_valid` drops to 0.
- Randomized: 1000 valid cycles with random `D` and random `conf` in 0..7, checked against the reference model `din[i]=D[i mod W]` (W=32 for `conf`≥5) at a 1-cycle offset. Include random asynchronous `rst_n` pulses, with outputs required to be 0 while reset is active.
